// File: rtl/jk_counter_register.sv
// WIDTH-bit JK / modulo up-down register for the SAP-2 datapath; all state changes on the falling edge of iClk.
// One falling edge from sampled inputs to oQ/oWrap; oTC and oQBar are combinational; no backpressure.
module jk_counter_register #(
    parameter int               WIDTH     = 4,
    parameter int               MOD       = 16,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             iClk,
    input  logic             iReset,
    input  logic             iLoad,
    input  logic [WIDTH-1:0] iData,
    input  logic             iEnable,
    input  logic [1:0]       iMode,
    input  logic [WIDTH-1:0] iJ,
    input  logic [WIDTH-1:0] iK,
    output logic [WIDTH-1:0] oQ,
    output logic [WIDTH-1:0] oQBar,
    output logic             oTC,
    output logic             oWrap
);

    localparam logic [1:0] MODE_JK   = 2'b00;
    localparam logic [1:0] MODE_UP   = 2'b01;
    localparam logic [1:0] MODE_DOWN = 2'b10;
    localparam logic [1:0] MODE_HOLD = 2'b11;

    // Highest in-range count; with MOD = 2^WIDTH this is all ones, giving natural roll-over.
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MOD - 1);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic             wrap_q;
    logic             wrap_d;
    logic             at_max;
    logic             at_zero;

    // Values loaded above MAX_VAL count as "at max" so up mode wraps them straight to 0.
    assign at_max  = (q_q >= MAX_VAL);
    assign at_zero = (q_q == '0);

    always_comb begin
        q_d    = q_q;
        wrap_d = 1'b0;
        if (iLoad) begin
            q_d = iData;
        end else if (iEnable) begin
            case (iMode)
                MODE_JK: begin
                    q_d = (iJ & ~q_q) | (~iK & q_q);
                end
                MODE_UP: begin
                    if (at_max) begin
                        q_d    = '0;
                        wrap_d = 1'b1;
                    end else begin
                        q_d = q_q + 1'b1;
                    end
                end
                MODE_DOWN: begin
                    if (at_zero) begin
                        q_d    = MAX_VAL;
                        wrap_d = 1'b1;
                    end else begin
                        q_d = q_q - 1'b1;
                    end
                end
                MODE_HOLD: begin
                    q_d = q_q;
                end
                default: begin
                    q_d = q_q;
                end
            endcase
        end
    end

    always_ff @(negedge iClk) begin
        if (!iReset) begin
            q_q    <= RESET_VAL;
            wrap_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            wrap_q <= wrap_d;
        end
    end

    assign oQ    = q_q;
    assign oQBar = ~q_q;
    assign oWrap = wrap_q;
    assign oTC   = iEnable & (((iMode == MODE_UP) & at_max) | ((iMode == MODE_DOWN) & at_zero));

endmodule

// File: tb/tb_jk_counter_register.sv
// Randomised and directed check of jk_counter_register (WIDTH=4, MOD=10, RESET_VAL=3) against an arithmetic model.
module tb_jk_counter_register;

    localparam int W   = 4;
    localparam int MD  = 10;
    localparam int RV  = 3;

    logic         iClk = 1'b1;
    logic         iReset = 1'b1;
    logic         iLoad = 1'b0;
    logic [W-1:0] iData = '0;
    logic         iEnable = 1'b0;
    logic [1:0]   iMode = 2'b11;
    logic [W-1:0] iJ = '0;
    logic [W-1:0] iK = '0;
    logic [W-1:0] oQ;
    logic [W-1:0] oQBar;
    logic         oTC;
    logic         oWrap;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: plain integers.
    int mq = RV;
    int mw = 0;

    jk_counter_register #(.WIDTH(W), .MOD(MD), .RESET_VAL(4'(RV))) dut (
        .iClk(iClk), .iReset(iReset), .iLoad(iLoad), .iData(iData),
        .iEnable(iEnable), .iMode(iMode), .iJ(iJ), .iK(iK),
        .oQ(oQ), .oQBar(oQBar), .oTC(oTC), .oWrap(oWrap)
    );

    always #5 iClk = ~iClk;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int model_tc(input int en, input int m, input int q);
        return (en != 0 && ((m == 1 && q >= MD - 1) || (m == 2 && q == 0))) ? 1 : 0;
    endfunction

    // Apply one set of inputs, check oTC before the edge, then state after it.
    task automatic step(input int rst_n, input int ld, input int d, input int en,
                        input int m, input int j, input int k);
        int nq;
        iReset  = rst_n[0];
        iLoad   = ld[0];
        iData   = d[W-1:0];
        iEnable = en[0];
        iMode   = m[1:0];
        iJ      = j[W-1:0];
        iK      = k[W-1:0];
        #1;
        check("tc", int'(oTC), model_tc(en, m, mq));
        @(negedge iClk);
        #1;
        nq = mq;
        mw = 0;
        if (rst_n == 0) begin
            nq = RV;
        end else if (ld != 0) begin
            nq = d;
        end else if (en != 0) begin
            if (m == 0) begin
                nq = 0;
                for (int b = 0; b < W; b++) begin
                    int jb, kb, qb, r;
                    jb = (j >> b) & 1;
                    kb = (k >> b) & 1;
                    qb = (mq >> b) & 1;
                    if (jb == 0 && kb == 0)      r = qb;
                    else if (jb == 0)            r = 0;
                    else if (kb == 0)            r = 1;
                    else                         r = 1 - qb;
                    nq += r << b;
                end
            end else if (m == 1) begin
                if (mq >= MD - 1) begin nq = 0; mw = 1; end
                else nq = mq + 1;
            end else if (m == 2) begin
                if (mq == 0) begin nq = MD - 1; mw = 1; end
                else nq = mq - 1;
            end
        end
        mq = nq;
        check("q", int'(oQ), mq);
        check("qbar", int'(oQBar), (~mq) & 15);
        check("wrap", int'(oWrap), mw);
    endtask

    initial begin
        // Reset, then count up and reset again; oQ must not move before the edge.
        #1;
        step(0, 0, 0, 0, 0, 0, 0);
        check("rst_q", int'(oQ), 3);
        check("rst_qbar", int'(oQBar), 12);
        check("rst_wrap", int'(oWrap), 0);
        check("rst_tc", int'(oTC), 0);
        step(1, 0, 0, 1, 1, 0, 0);
        step(1, 0, 0, 1, 1, 0, 0);
        iReset = 1'b0;
        #2;
        check("rst_before_edge", int'(oQ), 5);
        step(0, 1, 7, 1, 1, 0, 0);
        check("rst_over_load", int'(oQ), 3);

        // Decade count from 0.
        step(1, 1, 0, 0, 1, 0, 0);
        for (int i = 0; i < 12; i++) begin
            step(1, 0, 0, 1, 1, 0, 0);
            check("dec_q", int'(oQ), (i + 1) % 10);
            check("dec_wrap", int'(oWrap), ((i + 1) % 10 == 0) ? 1 : 0);
            iMode = 2'b01;
            iEnable = 1'b1;
            #1;
            check("dec_tc", int'(oTC), (oQ == 4'd9) ? 1 : 0);
        end

        // Down from an out-of-range load.
        step(1, 1, 12, 1, 2, 0, 0);
        for (int i = 0; i < 12; i++) begin
            step(1, 0, 0, 1, 2, 0, 0);
            check("down_q", int'(oQ), 11 - i);
            check("down_wrap", int'(oWrap), 0);
        end
        step(1, 0, 0, 1, 2, 0, 0);
        check("down_wrap_q", int'(oQ), 9);
        check("down_wrap_pulse", int'(oWrap), 1);

        // Per-bit JK.
        step(1, 1, 10, 0, 0, 0, 0);
        step(1, 0, 0, 1, 0, 12, 6);
        check("jk1", int'(oQ), 12);
        step(1, 0, 0, 1, 0, 12, 6);
        check("jk2", int'(oQ), 8);
        check("jk2_bar", int'(oQBar), 7);

        // Load beats a pending wrap.
        step(1, 1, 9, 0, 1, 0, 0);
        step(1, 1, 5, 1, 1, 0, 0);
        check("prio_q", int'(oQ), 5);
        check("prio_wrap", int'(oWrap), 0);

        // Enable gating in every mode.
        for (int m = 0; m < 4; m++) begin
            step(1, 1, (m == 2) ? 0 : 9, 0, m, 0, 0);
            for (int i = 0; i < 5; i++) begin
                step(1, 0, 0, 0, m, 15, 15);
                check("gate_q", int'(oQ), (m == 2) ? 0 : 9);
                check("gate_wrap", int'(oWrap), 0);
            end
        end

        // Reset mid-count discards a pending wrap.
        step(1, 1, 9, 0, 1, 0, 0);
        step(0, 0, 0, 1, 1, 0, 0);
        check("rst_wrap_drop", int'(oWrap), 0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 19) == 0) ? 0 : 1,
                 ($urandom_range(0, 7) == 0) ? 1 : 0,
                 int'($urandom_range(0, 15)),
                 ($urandom_range(0, 3) == 0) ? 0 : 1,
                 int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 15)),
                 int'($urandom_range(0, 15)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
